// File: rtl/req_pending_collector_5ch_pkg.sv
// req_pending_collector_5ch_pkg: shared widths, FSM states and popcount helper
package req_pending_collector_5ch_pkg;
  localparam int N_CH = 5;
  localparam int IDX_W = 3;
  localparam int DROP_CNT_W = 8;
  typedef enum logic {IDLE, OFFER} state_t;
  function automatic logic [IDX_W-1:0] popcnt(input logic [N_CH-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + IDX_W'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/req_pending_collector_5ch_sat_counter.sv
// sat_counter: saturating up-counter with variable increment and sync clear
module sat_counter #(
  parameter int W = 8,
  parameter int INC_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     cnt_o
);
  logic [W:0] sum;
  assign sum = {1'b0, cnt_o} + (W+1)'(inc_i);
  // clear beats increment; the carry bit pins the count at all-ones
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_o <= '0;
    else cnt_o <= clear_i ? '0 : sum[W] ? '1 : sum[W-1:0];
endmodule

// File: rtl/req_pending_collector_5ch.sv
// req_pending_collector_5ch: sticky request collector feeding an external priority encoder
module req_pending_collector_5ch
  import req_pending_collector_5ch_pkg::*;
#(
  parameter int DROP_CNT_W = req_pending_collector_5ch_pkg::DROP_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [N_CH-1:0]       req_pulse_i,
  output logic [N_CH-1:0]       pending_o,
  input  logic [IDX_W-1:0]      enc_idx_i,
  input  logic                  enc_valid_i,
  output logic                  grant_valid_o,
  output logic [IDX_W-1:0]      grant_idx_o,
  input  logic                  grant_ready_i,
  output logic [N_CH-1:0]       overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  input  logic                  clear_stats_i,
  output logic                  busy_o
);
  state_t state, state_nx;
  logic idx_ok, take, load;
  logic [N_CH-1:0] clr, coal;
  assign idx_ok = enc_valid_i && enc_idx_i < IDX_W'(N_CH) && |pending_o;
  assign take = state == IDLE || grant_ready_i;
  assign clr = load ? N_CH'(1) << enc_idx_i : '0;
  assign coal = req_pulse_i & pending_o & ~clr;
  assign grant_valid_o = state == OFFER;
  assign busy_o = |pending_o | grant_valid_o;
  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  // load a new index whenever the slot is free or being accepted this cycle
  always_comb begin
    load = take && idx_ok;
    state_nx = load ? OFFER : take ? IDLE : state;
  end
  // pending set wins over the served-bit clear; overflow tracks coalesced requests
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      pending_o <= '0;
      grant_idx_o <= '0;
      overflow_o <= '0;
    end else begin
      pending_o <= (pending_o & ~clr) | req_pulse_i;
      grant_idx_o <= load ? enc_idx_i : grant_idx_o;
      overflow_o <= clear_stats_i ? '0 : overflow_o | coal;
    end
  sat_counter #(.W(DROP_CNT_W), .INC_W(IDX_W)) u_drop (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .clear_i(clear_stats_i),
    .inc_i(popcnt(coal)),
    .cnt_o(drop_cnt_o)
  );
endmodule

// File: tb/tb_req_pending_collector_5ch.sv
// tb_req_pending_collector_5ch: directed scoreboard bench with an in-loop lowest-index-first encoder
module tb_req_pending_collector_5ch;
  import req_pending_collector_5ch_pkg::*;
  logic clk = 0, rst_n = 1, enc_valid, grant_valid, grant_ready = 1, clear_stats = 0, busy;
  logic [N_CH-1:0] req = '0, pending, overflow;
  logic [IDX_W-1:0] enc_idx, grant_idx;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic [IDX_W-1:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  req_pending_collector_5ch dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_pulse_i(req), .pending_o(pending),
    .enc_idx_i(enc_idx), .enc_valid_i(enc_valid), .grant_valid_o(grant_valid),
    .grant_idx_o(grant_idx), .grant_ready_i(grant_ready), .overflow_o(overflow),
    .drop_cnt_o(drop_cnt), .clear_stats_i(clear_stats), .busy_o(busy)
  );
  // encoder model: lowest set bit wins
  always_comb begin
    enc_valid = |pending;
    enc_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (pending[i]) enc_idx = IDX_W'(i);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (grant_valid && grant_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_unexpected: got idx %0d expected no grant", grant_idx);
          end else chk("grant_idx", 32'(grant_idx), 32'(exp_q.pop_front()));
        end
      end
    join_none
    #1 rst_n = 0;
    #1;
    chk("rst_pending", 32'(pending), 0);
    chk("rst_gvalid", 32'(grant_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    tick();
    rst_n = 1;
    tick();
    req = 5'b00100;
    exp_q.push_back(3'd2);
    tick();
    req = '0;
    chk("t1_pending", 32'(pending), 32'h04);
    chk("t1_gv_early", 32'(grant_valid), 0);
    tick();
    chk("t1_gv", 32'(grant_valid), 1);
    chk("t1_gidx", 32'(grant_idx), 2);
    chk("t1_pending_clr", 32'(pending), 0);
    tick();
    chk("t1_idle", 32'(grant_valid), 0);
    chk("t1_busy", 32'(busy), 0);
    req = 5'b10011;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd4);
    tick();
    req = '0;
    tick();
    chk("t2_g0", 32'(grant_idx), 0);
    tick();
    chk("t2_g1", 32'(grant_idx), 1);
    tick();
    chk("t2_g4", 32'(grant_idx), 4);
    chk("t2_busy_hi", 32'(busy), 1);
    tick();
    chk("t2_busy_lo", 32'(busy), 0);
    grant_ready = 0;
    req = 5'b00001;
    exp_q.push_back(3'd0);
    tick();
    req = '0;
    tick();
    chk("t3_gv", 32'(grant_valid), 1);
    chk("t3_pending0", 32'(pending), 0);
    req = 5'b00001;
    tick();
    chk("t3_repend", 32'(pending), 1);
    chk("t3_ovf0", 32'(overflow), 0);
    exp_q.push_back(3'd0);
    tick();
    req = '0;
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_cnt), 1);
    grant_ready = 1;
    tick();
    chk("t3_regrant", 32'(grant_valid), 1);
    chk("t3_pending_clr", 32'(pending), 0);
    tick();
    chk("t3_idle", 32'(grant_valid), 0);
    clear_stats = 1;
    tick();
    clear_stats = 0;
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_clr_drop", 32'(drop_cnt), 0);
    grant_ready = 0;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    req = 5'b01000;
    tick();
    tick();
    req = '0;
    chk("t4_gidx", 32'(grant_idx), 3);
    chk("t4_pending", 32'(pending), 32'h08);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_drop", 32'(drop_cnt), 0);
    grant_ready = 1;
    tick();
    chk("t4_second", 32'(grant_valid), 1);
    chk("t4_pending_clr", 32'(pending), 0);
    tick();
    chk("t4_busy", 32'(busy), 0);
    grant_ready = 0;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    req = 5'b00010;
    tick();
    tick();
    chk("t5_repend", 32'(drop_cnt), 0);
    repeat (254) tick();
    chk("t5_drop254", 32'(drop_cnt), 254);
    repeat (46) tick();
    chk("t5_sat", 32'(drop_cnt), 255);
    chk("t5_ovf", 32'(overflow), 32'h02);
    clear_stats = 1;
    tick();
    clear_stats = 0;
    req = '0;
    chk("t5_clr_wins", 32'(drop_cnt), 0);
    chk("t5_clr_ovf", 32'(overflow), 0);
    tick();
    chk("t5_after_clr", 32'(drop_cnt), 0);
    grant_ready = 1;
    repeat (3) tick();
    chk("t5_idle", 32'(grant_valid), 0);
    grant_ready = 0;
    req = 5'b11010;
    tick();
    req = '0;
    tick();
    req = 5'b00010;
    tick();
    req = '0;
    chk("t6_pre_pending", 32'(pending), 32'h1a);
    chk("t6_pre_gv", 32'(grant_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_pending", 32'(pending), 0);
    chk("t6_gv", 32'(grant_valid), 0);
    chk("t6_gidx", 32'(grant_idx), 0);
    chk("t6_busy", 32'(busy), 0);
    tick();
    rst_n = 1;
    grant_ready = 1;
    repeat (4) tick();
    chk("t6_no_grant", 32'(grant_valid), 0);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
